muldiv_ctrl: RTL and testbench

//  Iterative multiply/divide sequencer with the HI/LO register pair for the 5-stage MIPS pipeline.
//  - Placement: sits beside the E-stage ALU.
//  - Sequences a one-bit-per-cycle shift-add / restoring-subtract datapath for MULT/MULTU/DIV/DIVU.
//  - Services MTHI/MTLO.
//  - Raises a stall to the hazard logic while a result is pending.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_ctrl.sv | 151 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared multiply/divide definitions: op codes, sequencer state encodings and op decode helpers.
package mips_pkg;

   localparam logic [2:0] MD_OP_MULT  = 3'b000;
   localparam logic [2:0] MD_OP_MULTU = 3'b001;
   localparam logic [2:0] MD_OP_DIV   = 3'b010;
   localparam logic [2:0] MD_OP_DIVU  = 3'b011;
   localparam logic [2:0] MD_OP_MTHI  = 3'b100;
   localparam logic [2:0] MD_OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      MD_IDLE  = 2'd0,
      MD_CALC  = 2'd1,
      MD_FIXUP = 2'd2
   } md_state_t;

   function automatic logic md_is_arith(input logic [2:0] op);
      return op[2] == 1'b0;
   endfunction

   function automatic logic md_is_signed(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational multiply/divide iteration: shift-add for MUL, restoring subtract for DIV.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [2*WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]     mplier,
   output logic [2*WIDTH-1:0]   acc_next,
   output logic [2*WIDTH-1:0]   mcand_next,
   output logic [WIDTH-1:0]     mplier_next
);

   logic [2*WIDTH-1:0] sum;
   logic [WIDTH:0]     part;
   logic [WIDTH:0]     diff;
   logic               borrow;

   // DIV keeps {remainder, quotient} in acc; the top WIDTH+1 bits after the
   // left shift form the partial remainder, so a divisor with MSB set still compares correctly.
   assign part            = acc[2*WIDTH-1:WIDTH-1];
   assign {borrow, diff}  = {1'b0, part} - {2'b00, mcand[WIDTH-1:0]};
   assign sum             = acc + mcand;

   always_comb begin
      acc_next    = acc;
      mcand_next  = mcand;
      mplier_next = mplier;
      if (is_div) begin
         acc_next = {(borrow ? part[WIDTH-1:0] : diff[WIDTH-1:0]), acc[WIDTH-2:0], ~borrow};
      end else begin
         acc_next    = mplier[0] ? sum : acc;
         mcand_next  = {mcand[2*WIDTH-2:0], 1'b0};
         mplier_next = {1'b0, mplier[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS multiply/divide sequencer with HI/LO. Define MULDIV_EARLY_OUT_EN to let
// multiplies finish once the remaining multiplier bits are all zero.
module muldiv_ctrl
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             hilo_rd,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   md_state_t          state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc, mcand;
   logic [WIDTH-1:0]   mplier, orig_a;
   logic               is_div, neg_res, neg_rem, dz;

   logic [2*WIDTH-1:0] acc_next, mcand_next;
   logic [WIDTH-1:0]   mplier_next;
   logic               sgn, early_out;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;

   assign sgn   = md_is_signed(op);
   assign abs_a = (sgn && srcA[WIDTH-1]) ? (~srcA + 1'b1) : srcA;
   assign abs_b = (sgn && srcB[WIDTH-1]) ? (~srcB + 1'b1) : srcB;

   assign stall = busy & (start | hilo_rd);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div      (is_div),
      .acc         (acc),
      .mcand       (mcand),
      .mplier      (mplier),
      .acc_next    (acc_next),
      .mcand_next  (mcand_next),
      .mplier_next (mplier_next)
   );

`ifdef MULDIV_EARLY_OUT_EN
   assign early_out = !is_div && (mplier_next == '0);
`else
   assign early_out = 1'b0;
`endif

   // Sign correction applied on the unsigned magnitude result.
   assign prod = neg_res ? (~acc + 1'b1) : acc;
   assign quo  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
   assign rem  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= MD_IDLE;
         cnt     <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         orig_a  <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         dz      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            MD_IDLE: begin
               if (start && !flush) begin
                  if (md_is_arith(op)) begin
                     is_div  <= op[1];
                     neg_res <= sgn & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                     neg_rem <= sgn & srcA[WIDTH-1];
                     dz      <= (srcB == '0);
                     orig_a  <= srcA;
                     mplier  <= abs_b;
                     cnt     <= CW'(WIDTH-1);
                     state   <= MD_CALC;
                     busy    <= 1'b1;
                     if (op[1]) begin
                        acc   <= {{WIDTH{1'b0}}, abs_a};
                        mcand <= {{WIDTH{1'b0}}, abs_b};
                     end else begin
                        acc   <= '0;
                        mcand <= {{WIDTH{1'b0}}, abs_a};
                     end
                  end else if (op == MD_OP_MTHI) begin
                     hi <= srcA;
                  end else if (op == MD_OP_MTLO) begin
                     lo <= srcA;
                  end
               end
            end
            MD_CALC: begin
               if (flush) begin
                  state <= MD_IDLE;
                  busy  <= 1'b0;
               end else begin
                  acc    <= acc_next;
                  mcand  <= mcand_next;
                  mplier <= mplier_next;
                  cnt    <= cnt - 1'b1;
                  if (cnt == '0 || early_out)
                     state <= MD_FIXUP;
               end
            end
            MD_FIXUP: begin
               state <= MD_IDLE;
               busy  <= 1'b0;
               if (!flush) begin
                  done <= 1'b1;
                  if (is_div) begin
                     // Divide by zero returns the dividend in HI and all-ones in LO.
                     if (dz) begin
                        hi <= orig_a;
                        lo <= '1;
                     end else begin
                        hi <= rem;
                        lo <= quo;
                     end
                  end else begin
                     hi <= prod[2*WIDTH-1:WIDTH];
                     lo <= prod[WIDTH-1:0];
                  end
               end
            end
            default: begin
               state <= MD_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed ops push expected HI/LO, a done-driven monitor checks them.
module tb_muldiv_ctrl;
   import mips_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EO = 1'b1;
`else
   localparam bit EO = 1'b0;
`endif

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic        clk, reset, flush, start, hilo_rd;
   logic [2:0]  op;
   logic [31:0] srcA, srcB;
   logic        busy, stall, done;
   logic [31:0] hi, lo;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .flush(flush), .start(start), .op(op),
      .srcA(srcA), .srcB(srcB), .hilo_rd(hilo_rd),
      .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: hi=%h lo=%h with no op outstanding", hi, lo);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (hi !== e.hi || lo !== e.lo) begin
               errors++;
               $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e.hi, e.lo);
            end
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      start = 1'b1; op = o; srcA = a; srcB = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'b111;
   endtask

   task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int eb, input bit rd);
      int  n;
      bit  timed_out;
      sb.push_back('{eh, el});
      issue(o, a, b);
      if (rd) hilo_rd = 1'b1;
      n = 0;
      timed_out = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
         n++;
         if (rd && n == 1) chk({nm, "_stall_busy"}, stall, 1);
      end
      if (timed_out) $display("FAIL %s_timeout: busy never fell within 200 cycles", nm);
      chk({nm, "_busy_cycles"}, n, eb);
      if (rd) chk({nm, "_stall_idle"}, stall, 0);
      hilo_rd = 1'b0;
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; start = 1'b0; hilo_rd = 1'b0;
      op = 3'b111; srcA = '0; srcB = '0;

      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      @(posedge clk); #1;
      reset = 1'b1;

      run_op("mult_m3x5",   MD_OP_MULT,  32'hFFFFFFFD, 32'd5,       32'hFFFFFFFF, 32'hFFFFFFF1, EO ? 4 : 33, 1'b0);
      run_op("div_m7d2",    MD_OP_DIV,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
      run_op("divu_100d0",  MD_OP_DIVU,  32'd100,      32'd0,       32'h00000064, 32'hFFFFFFFF, 33, 1'b0);
      run_op("multu_2p16",  MD_OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, EO ? 18 : 33, 1'b1);
      run_op("div_minint",  MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0);
      run_op("div_7dm2",    MD_OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b0);
      run_op("multu_max",   MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0);
      run_op("divu_msb",    MD_OP_DIVU,  32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 33, 1'b0);
      run_op("div_m5d0",    MD_OP_DIV,   32'hFFFFFFFB, 32'd0,       32'hFFFFFFFB, 32'hFFFFFFFF, 33, 1'b0);
      run_op("multu_7x3",   MD_OP_MULTU, 32'd7,        32'd3,       32'h00000000, 32'h00000015, EO ? 3 : 33, 1'b0);

      // MTHI/MTLO write immediately, without busy or done.
      issue(MD_OP_MTHI, 32'hAAAA0000, 32'd0);
      @(negedge clk);
      chk("mthi_hi", hi, 32'hAAAA0000);
      chk("mthi_busy", busy, 0);
      issue(MD_OP_MTLO, 32'h00005555, 32'd0);
      @(negedge clk);
      chk("mtlo_lo", lo, 32'h00005555);

      // Flush on the tenth busy cycle aborts with no done and HI/LO untouched.
      issue(MD_OP_MULTU, 32'd3, 32'h80000001);
      for (int k = 0; k < 10; k++) @(negedge clk);
      chk("flush_busy_pre", busy, 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy_post", busy, 0);
      for (int k = 0; k < 40; k++) @(negedge clk);
      chk("flush_hi", hi, 32'hAAAA0000);
      chk("flush_lo", lo, 32'h00005555);

      // Start alongside flush in IDLE is dropped.
      @(posedge clk); #1;
      flush = 1'b1; start = 1'b1; op = MD_OP_MTHI; srcA = 32'h00001234;
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0; op = 3'b111;
      @(negedge clk);
      chk("flush_start_hi", hi, 32'hAAAA0000);
      chk("flush_start_busy", busy, 0);

      // Asynchronous reset mid-divide.
      issue(MD_OP_DIV, 32'd100, 32'd3);
      for (int k = 0; k < 5; k++) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      chk("midrst_done", done, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      run_op("divu_after_rst", MD_OP_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 33, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
